serial_deframer: RTL and testbench
==================================

SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 Parameter W, default 8: data word width in bits; legal range W >= 2.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ser_in  input  1  serial data bit, LSB first, from the upstream right-shifting PISO serial output.
REQ-005 ser_valid  input  1  ser_in is sampled on every rising edge where this is high (the upstream shift enable).
REQ-006 start  input  1  single-cycle frame marker (the upstream load strobe); arms reception of a new frame.
REQ-007 out_ready  input  1  downstream accepts the word on a rising edge where out_valid and out_ready are both high.
REQ-008 clr_overrun  input  1  synchronous clear of the overrun flag.
REQ-009 data  output  W  assembled word; bit 0 is the first serial bit received.
REQ-010 out_valid  output  1  data (and parity_err) are valid and held stable.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-013 parity_err  output  1  parity result for the word in data (see Configuration).

Function
REQ-014 States: IDLE, RECV, PARITY (present only with the macro); a bit counter of width $clog2(W+1) counts data bits sampled in RECV.
REQ-015 IDLE: start -> RECV, counter cleared; ser_valid is ignored.
REQ-016 RECV: each ser_valid edge shifts an internal register right with ser_in entering bit W-1 and increments the counter.
REQ-017 On the edge sampling the Wth data bit, the frame completes (without the macro) and the state returns to IDLE.
REQ-018 On frame completion, data takes the assembled word and out_valid is high from the following cycle: latency 1 clock after the last sampled bit.
REQ-019 out_valid stays high, with data and parity_err unchanged, until the edge where out_ready is high; it then clears unless a frame completes on that same edge.
REQ-020 Completion while out_valid=1 and out_ready=0: data is not overwritten, the new word is dropped, overrun is set.
REQ-021 Completion on the same edge as an accepting out_ready: the new word loads, out_valid stays 1, overrun is not set.
REQ-022 start in RECV or PARITY aborts the partial frame (no output, no flag) and restarts at counter 0.
REQ-023 start and ser_valid high together: start has priority and that ser_in bit is discarded.
REQ-024 overrun clears on clr_overrun; a set in the same cycle as clr_overrun takes priority over the clear.
REQ-025 busy = (state != IDLE); combinational from the state register.

Reset
REQ-026 While reset_n=0: state=IDLE, counter=0, shift register=0, data=0, out_valid=0, overrun=0, parity_err=0, busy=0.
REQ-027 Reset asserted mid-frame discards the partial frame; after release, reception waits for a fresh start.

Configuration
REQ-028 Macro SERIAL_DEFRAMER_PARITY_EN defined: after W data bits the state moves to PARITY; the next ser_valid sample is an even-parity bit that completes the frame.
REQ-029 With the macro, parity_err = XOR of the W data bits and the parity bit, registered together with data.
REQ-030 Macro undefined: no PARITY state, frames are exactly W bits, and parity_err is held at 0.

Verification
REQ-031 Reset, start, then 8 ser_valid bits 0,0,0,0,1,1,0,1 -> data=8'hB0 and out_valid=1 one cycle after the 8th bit; busy=0 afterwards.
REQ-032 out_ready=0, then a second complete frame 8'h5A -> data stays 8'hB0, overrun=1; clr_overrun pulse -> overrun=0.
REQ-033 out_ready=1 on the completion edge of frame 8'h3C while holding 8'hB0 -> data=8'h3C, out_valid stays 1, overrun=0.
REQ-034 start after 3 bits, then 8 new bits 8'hFF -> data=8'hFF with no output from the aborted frame.
REQ-035 reset_n pulsed low after 5 bits -> all outputs 0; ser_valid toggling without start produces no out_valid.
REQ-036 PARITY_EN: 8'hB0 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_deframer.sv
// Serial-to-parallel frame receiver: LSB-first bits after a start strobe, one-deep output holding register.
// Optional trailing even-parity bit enabled by defining SERIAL_DEFRAMER_PARITY_EN.
module serial_deframer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ser_in,
    input  logic         ser_valid,
    input  logic         start,
    input  logic         out_ready,
    input  logic         clr_overrun,
    output logic [W-1:0] data,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECV   = 2'd1;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          perr_q, perr_d;

    logic          done;
    logic [W-1:0]  word;
    logic          par;
    logic          ovr_set;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        word    = shreg_q;
        par     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                end
            end
            S_RECV: begin
                // start outranks ser_valid: the coincident bit is dropped
                if (start) begin
                    cnt_d = '0;
                end else if (ser_valid) begin
                    shreg_d = {ser_in, shreg_q[W-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
                        state_d = S_PARITY;
`else
                        done    = 1'b1;
                        word    = shreg_d;
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef SERIAL_DEFRAMER_PARITY_EN
            S_PARITY: begin
                if (start) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                end else if (ser_valid) begin
                    done    = 1'b1;
                    word    = shreg_q;
                    par     = (^shreg_q) ^ ser_in;
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_set = 1'b0;
        if (done) begin
            // an accepting out_ready on the completion edge frees the slot for the new word
            if (!valid_q || out_ready) begin
                data_d  = word;
                perr_d  = par;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign data       = data_q;
    assign out_valid  = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = ovr_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: directed scenarios followed by random traffic, checked against a
// frame-level model (bit queue per frame, one-slot output holder). Honours SERIAL_DEFRAMER_PARITY_EN.
module tb_serial_deframer;

    localparam int W = 8;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk;
    logic         reset_n;
    logic         ser_in;
    logic         ser_valid;
    logic         start;
    logic         out_ready;
    logic         clr_overrun;
    logic [W-1:0] data;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int vectors = 0;
    int errors  = 0;

    serial_deframer #(.W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .start      (start),
        .out_ready  (out_ready),
        .clr_overrun(clr_overrun),
        .data       (data),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: frame-level view
    bit           m_armed;
    bit           m_bits[$];
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovr;
    logic         m_perr;

    task automatic model_reset();
        m_armed = 0;
        m_bits.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic sv, input logic si,
                              input logic rdy, input logic clr);
        bit           complete;
        logic [W-1:0] nw;
        logic         np;
        bit           set;
        complete = 0;
        nw       = '0;
        np       = 1'b0;
        set      = 0;
        if (st) begin
            m_armed = 1;
            m_bits.delete();
        end else if (m_armed && sv) begin
            m_bits.push_back(si);
            if (m_bits.size() == FL) begin
                complete = 1;
                for (int i = 0; i < W; i++) nw[i] = m_bits[i];
`ifdef SERIAL_DEFRAMER_PARITY_EN
                for (int i = 0; i < FL; i++) np = np ^ m_bits[i];
`endif
                m_armed = 0;
                m_bits.delete();
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_data  = nw;
                m_perr  = np;
                m_valid = 1'b1;
            end else begin
                set = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (set)      m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},       32'(data),       32'(m_data));
        chk({tag, ".out_valid"},  32'(out_valid),  32'(m_valid));
        chk({tag, ".busy"},       32'(busy),       32'(m_armed));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
    endtask

    task automatic step(input string tag, input logic st, input logic sv, input logic si,
                        input logic rdy, input logic clr);
        start       = st;
        ser_valid   = sv;
        ser_in      = si;
        out_ready   = rdy;
        clr_overrun = clr;
        @(posedge clk);
        model_edge(st, sv, si, rdy, clr);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // start, then FL bits; out_ready only on the final (completion) edge
    task automatic send_frame(input string tag, input logic [W-1:0] w,
                              input logic rdy_last, input logic pbit);
        logic [W:0] fr;
        fr = {pbit, w};
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < FL; i++)
            step(tag, 1'b0, 1'b1, fr[i], (i == FL - 1) ? rdy_last : 1'b0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
        model_reset();
        async_reset("reset");
        idle("post_reset");

        send_frame("frameB0", 8'hB0, 1'b0, ^8'hB0);
        chk("frameB0.const_data", 32'(data), 32'h0000_00B0);
        chk("frameB0.const_valid", 32'(out_valid), 32'd1);
        chk("frameB0.const_busy", 32'(busy), 32'd0);
        idle("hold");

        send_frame("overrun", 8'h5A, 1'b0, ^8'h5A);
        chk("overrun.const_data", 32'(data), 32'h0000_00B0);
        chk("overrun.const_flag", 32'(overrun), 32'd1);
        step("clr_overrun", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_overrun.const_flag", 32'(overrun), 32'd0);

        send_frame("accept_same_edge", 8'h3C, 1'b1, ^8'h3C);
        chk("accept_same_edge.const_data", 32'(data), 32'h0000_003C);
        chk("accept_same_edge.const_valid", 32'(out_valid), 32'd1);
        chk("accept_same_edge.const_ovr", 32'(overrun), 32'd0);
        step("drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain.const_valid", 32'(out_valid), 32'd0);

        step("abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("restart_with_sv", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < FL; i++) step("frameFF", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifndef SERIAL_DEFRAMER_PARITY_EN
        chk("frameFF.const_data", 32'(data), 32'h0000_00FF);
`endif
        step("drain2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        step("midreset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("midreset", 1'b0, 1'b1, 1'(i), 1'b0, 1'b0);
        async_reset("midreset.rst");
        for (int i = 0; i < 12; i++)
            step("no_start", 1'b0, 1'(i % 2), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("no_start.const_valid", 32'(out_valid), 32'd0);

`ifdef SERIAL_DEFRAMER_PARITY_EN
        send_frame("par_ok", 8'hB0, 1'b1, 1'b1);
        chk("par_ok.const_perr", 32'(parity_err), 32'd0);
        send_frame("par_bad", 8'hB0, 1'b1, 1'b0);
        chk("par_bad.const_perr", 32'(parity_err), 32'd1);
        step("drain3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        for (int n = 0; n < 800; n++) begin
            if (n == 400) async_reset("rand.rst");
            step("rand",
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
